speed_monitor: RTL and testbench

//  Multi-channel, parametrised speed-violation monitor; successor to the single-lane checker.
//  Per channel: escalates through WARN_LEVELS warning levels on accel_in, issues a one-cycle

---
 rtl/speed_pkg.sv | 18 +
 rtl/speed_lane.sv | 104 ++++++++++
 rtl/speed_monitor.sv | 57 +++++
 tb/tb_speed_monitor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Shared definitions for the speed monitor: level encodings, width helpers and
// default parameter values.
package speed_pkg;

  localparam int unsigned LVL_LEGAL = 0;

  localparam int unsigned DEF_NCH         = 4;
  localparam int unsigned DEF_WARN_LEVELS = 1;
  localparam int unsigned DEF_HOLDOFF     = 1;
  localparam int unsigned DEF_COOL_CYCLES = 0;
  localparam int unsigned DEF_CNT_W       = 8;

  // Width needed to hold 0..max_val; at least 1 so zero-sized vectors never appear.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/speed_lane.sv
// One monitor channel: warning-level escalation, post-ticket hold-off, quiet-time
// decay, registered ticket pulse and saturating ticket counter.
module speed_lane
  import speed_pkg::*;
#(
  parameter int unsigned WARN_LEVELS = DEF_WARN_LEVELS,
  parameter int unsigned HOLDOFF     = DEF_HOLDOFF,
  parameter int unsigned COOL_CYCLES = DEF_COOL_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  localparam int unsigned LVL_W      = cnt_w(WARN_LEVELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             accel,
  input  logic             clear_cnt,
  output logic             fire,
  output logic             ticket,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] cnt
);

  localparam int unsigned HOLD_W  = cnt_w(HOLDOFF);
  localparam int unsigned QUIET_W = cnt_w(COOL_CYCLES);

  localparam logic [LVL_W-1:0]   LvlLegal  = LVL_W'(LVL_LEGAL);
  localparam logic [LVL_W-1:0]   LvlMax    = LVL_W'(WARN_LEVELS);
  localparam logic [HOLD_W-1:0]  HoldInit  = HOLD_W'(HOLDOFF);
  localparam logic [QUIET_W-1:0] QuietLast = QUIET_W'((COOL_CYCLES == 0) ? 0 : COOL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CntMax    = {CNT_W{1'b1}};
  localparam bit                 DecayEn   = (COOL_CYCLES != 0);

  logic [LVL_W-1:0]   level_q, level_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [QUIET_W-1:0] quiet_q, quiet_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ticket_q;
  logic               fire_d;

  always_comb begin
    level_d = level_q;
    hold_d  = hold_q;
    quiet_d = quiet_q;
    fire_d  = 1'b0;
    if (enable) begin
      if (hold_q != '0) begin
        hold_d  = hold_q - 1'b1;
        level_d = LvlLegal;
        quiet_d = '0;
      end else if (accel) begin
        quiet_d = '0;
        if (level_q == LvlMax) begin
          fire_d  = 1'b1;
          level_d = LvlLegal;
          hold_d  = HoldInit;
        end else begin
          level_d = level_q + 1'b1;
        end
      end else if (DecayEn && (level_q != LvlLegal)) begin
        // Drop one level on the COOL_CYCLES-th consecutive quiet cycle.
        if (quiet_q == QuietLast) begin
          level_d = level_q - 1'b1;
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end else begin
        quiet_d = '0;
      end
    end
  end

  // A clear coinciding with a ticket keeps that ticket in the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_cnt) begin
      cnt_d = fire_d ? CNT_W'(1) : '0;
    end else if (fire_d && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q  <= LvlLegal;
      hold_q   <= '0;
      quiet_q  <= '0;
      cnt_q    <= '0;
      ticket_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      hold_q   <= hold_d;
      quiet_q  <= quiet_d;
      cnt_q    <= cnt_d;
      ticket_q <= fire_d;
    end
  end

  assign fire   = fire_d;
  assign ticket = ticket_q;
  assign level  = level_q;
  assign cnt    = cnt_q;

endmodule

// File: rtl/speed_monitor.sv
// Multi-channel speed-violation monitor: NCH independent lanes plus a registered
// any-ticket summary aligned with the per-lane ticket pulses.
module speed_monitor
  import speed_pkg::*;
#(
  parameter int unsigned NCH         = DEF_NCH,
  parameter int unsigned WARN_LEVELS = DEF_WARN_LEVELS,
  parameter int unsigned HOLDOFF     = DEF_HOLDOFF,
  parameter int unsigned COOL_CYCLES = DEF_COOL_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  localparam int unsigned LVL_W      = cnt_w(WARN_LEVELS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NCH-1:0]       accel_in,
  input  logic                 clear_cnt,
  output logic [NCH-1:0]       get_ticket,
  output logic [NCH*LVL_W-1:0] warn_level,
  output logic [NCH*CNT_W-1:0] ticket_cnt,
  output logic                 any_ticket
);

  logic [NCH-1:0] fire;
  logic           any_ticket_q;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    speed_lane #(
      .WARN_LEVELS(WARN_LEVELS),
      .HOLDOFF    (HOLDOFF),
      .COOL_CYCLES(COOL_CYCLES),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .accel    (accel_in[i]),
      .clear_cnt(clear_cnt),
      .fire     (fire[i]),
      .ticket   (get_ticket[i]),
      .level    (warn_level[i*LVL_W +: LVL_W]),
      .cnt      (ticket_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Built from lane next-state so it lands in the same cycle as get_ticket.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_ticket_q <= 1'b0;
    end else begin
      any_ticket_q <= |fire;
    end
  end

  assign any_ticket = any_ticket_q;

endmodule

// File: tb/tb_speed_monitor.sv
// Directed bench for speed_monitor: a default-parameter instance and one with
// three warning levels, quiet-time decay and a 2-bit ticket counter.
module tb_speed_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (NCH=4, WARN_LEVELS=1, HOLDOFF=1, COOL_CYCLES=0, CNT_W=8)
  logic       a_rst, a_en, a_clr, a_any;
  logic [3:0] a_accel, a_tk, a_lvl;
  logic [31:0] a_cnt;

  // Instance B: WARN_LEVELS=3, COOL_CYCLES=4, CNT_W=2
  logic       b_rst, b_en, b_clr, b_any;
  logic [3:0] b_accel, b_tk;
  logic [7:0] b_lvl, b_cnt;

  speed_monitor u_a (
    .clk       (clk),
    .reset     (a_rst),
    .enable    (a_en),
    .accel_in  (a_accel),
    .clear_cnt (a_clr),
    .get_ticket(a_tk),
    .warn_level(a_lvl),
    .ticket_cnt(a_cnt),
    .any_ticket(a_any)
  );

  speed_monitor #(
    .NCH        (4),
    .WARN_LEVELS(3),
    .HOLDOFF    (1),
    .COOL_CYCLES(4),
    .CNT_W      (2)
  ) u_b (
    .clk       (clk),
    .reset     (b_rst),
    .enable    (b_en),
    .accel_in  (b_accel),
    .clear_cnt (b_clr),
    .get_ticket(b_tk),
    .warn_level(b_lvl),
    .ticket_cnt(b_cnt),
    .any_ticket(b_any)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full ticket cycle on B ch1: three escalations, ticket, then the hold-off cycle.
  task automatic b_ticket_ch1(input logic [1:0] exp_cnt, input string tag);
    b_accel = 4'b0010;
    for (int k = 0; k < 3; k++) step();
    step();
    check({tag, "_tk"}, 32'(b_tk), 32'h2);
    check({tag, "_cnt"}, 32'(b_cnt[3:2]), 32'(exp_cnt));
    b_accel = 4'b0000;
    step();
  endtask

  initial begin
    a_rst = 1'b1; a_en = 1'b1; a_clr = 1'b0; a_accel = '0;
    b_rst = 1'b1; b_en = 1'b1; b_clr = 1'b0; b_accel = '0;
    step(); step();
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset state
    check("rst_a_tk",  32'(a_tk),  32'h0);
    check("rst_a_lvl", 32'(a_lvl), 32'h0);
    check("rst_a_cnt", a_cnt,      32'h0);
    check("rst_a_any", 32'(a_any), 32'h0);
    check("rst_b_lvl", 32'(b_lvl), 32'h0);
    check("rst_b_cnt", 32'(b_cnt), 32'h0);

    // 1: defaults, ch0 accel for 3 cycles
    a_accel = 4'b0001;
    step();
    check("t1_lvl1", 32'(a_lvl[0]), 32'h1);
    check("t1_tk1",  32'(a_tk),     32'h0);
    step();
    check("t1_lvl2", 32'(a_lvl[0]), 32'h0);
    check("t1_tk2",  32'(a_tk),     32'h1);
    check("t1_any2", 32'(a_any),    32'h1);
    check("t1_cnt2", a_cnt,         32'h0000_0001);
    step();
    check("t1_lvl3", 32'(a_lvl[0]), 32'h0);
    check("t1_tk3",  32'(a_tk),     32'h0);
    check("t1_any3", 32'(a_any),    32'h0);
    check("t1_cnt3", a_cnt,         32'h0000_0001);
    a_accel = 4'b0000;
    step();

    // 2: three levels on B ch2
    b_accel = 4'b0100;
    step(); check("t2_lvl1", 32'(b_lvl[5:4]), 32'h1); check("t2_tk1", 32'(b_tk), 32'h0);
    step(); check("t2_lvl2", 32'(b_lvl[5:4]), 32'h2);
    step(); check("t2_lvl3", 32'(b_lvl[5:4]), 32'h3); check("t2_tk3", 32'(b_tk), 32'h0);
    step();
    check("t2_lvl4", 32'(b_lvl[5:4]), 32'h0);
    check("t2_tk4",  32'(b_tk),       32'h4);
    check("t2_any4", 32'(b_any),      32'h1);
    check("t2_cnt",  32'(b_cnt),      32'h10);
    check("t2_other_lvl", 32'(b_lvl), 32'h0);
    b_accel = 4'b0000;
    step();
    check("t2_tk5", 32'(b_tk), 32'h0);

    // 3: decay on B ch0 from level 2 over 8 quiet cycles
    b_accel = 4'b0001;
    step(); step();
    check("t3_lvl_start", 32'(b_lvl[1:0]), 32'h2);
    b_accel = 4'b0000;
    for (int k = 0; k < 3; k++) step();
    check("t3_lvl_q3", 32'(b_lvl[1:0]), 32'h2);
    step();
    check("t3_lvl_q4", 32'(b_lvl[1:0]), 32'h1);
    for (int k = 0; k < 3; k++) step();
    check("t3_lvl_q7", 32'(b_lvl[1:0]), 32'h1);
    step();
    check("t3_lvl_q8", 32'(b_lvl[1:0]), 32'h0);

    // 4: 2-bit counter saturation on B ch1, then clear with a same-cycle ticket
    b_ticket_ch1(2'd1, "t4_n1");
    b_ticket_ch1(2'd2, "t4_n2");
    b_ticket_ch1(2'd3, "t4_n3");
    b_ticket_ch1(2'd3, "t4_n4");
    b_ticket_ch1(2'd3, "t4_n5");
    check("t4_ch2_before_clr", 32'(b_cnt[5:4]), 32'h1);
    b_accel = 4'b0010;
    for (int k = 0; k < 3; k++) step();
    b_clr = 1'b1;
    step();
    b_clr = 1'b0; b_accel = 4'b0000;
    check("t4_clr_tk",  32'(b_tk),       32'h2);
    check("t4_clr_ch1", 32'(b_cnt[3:2]), 32'h1);
    check("t4_clr_ch2", 32'(b_cnt[5:4]), 32'h0);
    step();

    // 5: enable low freezes state; clear_cnt still honoured
    a_accel = 4'b0010;
    step();
    check("t5_lvl_pre", 32'(a_lvl[1]), 32'h1);
    a_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5_frozen_tk", 32'(a_tk), 32'h0);
    end
    check("t5_frozen_lvl", 32'(a_lvl[1]), 32'h1);
    check("t5_frozen_any", 32'(a_any),    32'h0);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    check("t5_clr_while_off", a_cnt, 32'h0);
    a_en = 1'b1;
    step();
    check("t5_tk",     32'(a_tk),  32'h2);
    check("t5_any",    32'(a_any), 32'h1);
    check("t5_cnt",    a_cnt,      32'h0000_0100);
    a_accel = 4'b0000;
    step(); step();

    // 6: reset while a ticket is about to fire
    a_accel = 4'b1000;
    step();
    check("t6_lvl_pre", 32'(a_lvl[3]), 32'h1);
    a_rst = 1'b1;
    step();
    check("t6_tk",  32'(a_tk),  32'h0);
    check("t6_any", 32'(a_any), 32'h0);
    check("t6_lvl", 32'(a_lvl), 32'h0);
    check("t6_cnt", a_cnt,      32'h0);
    a_rst = 1'b0; a_accel = 4'b0000;
    step();
    check("t6_tk_after", 32'(a_tk), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
